// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the multicycle sequencer: states, opcode classes,
// mux selects, fault codes and the strobe bundle passed from decode to top.
package multicycle_pkg;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_EXEC_R  = 4'd2;
  localparam logic [3:0] S_EXEC_I  = 4'd3;
  localparam logic [3:0] S_WB_ALU  = 4'd4;
  localparam logic [3:0] S_EXEC_BR = 4'd5;
  localparam logic [3:0] S_JUMP    = 4'd6;
  localparam logic [3:0] S_LDI     = 4'd7;
  localparam logic [3:0] S_ADDR    = 4'd8;
  localparam logic [3:0] S_MEM_LD  = 4'd9;
  localparam logic [3:0] S_WB_LD   = 4'd10;
  localparam logic [3:0] S_MEM_ST  = 4'd11;
  localparam logic [3:0] S_HALT    = 4'd12;
  localparam logic [3:0] S_FAULT   = 4'd13;

  typedef enum logic [1:0] {
    CLS_ALU_R  = 2'd0,
    CLS_ALU_I  = 2'd1,
    CLS_BRANCH = 2'd2,
    CLS_MISC   = 2'd3
  } op_class_t;

  localparam logic [3:0] SUB_LOAD  = 4'h0;
  localparam logic [3:0] SUB_STORE = 4'h1;
  localparam logic [3:0] SUB_JUMP  = 4'h2;
  localparam logic [3:0] SUB_LDI   = 4'h3;
  localparam logic [3:0] SUB_HALT  = 4'hF;

  localparam logic [1:0] WD_MDR     = 2'd0;
  localparam logic [1:0] WD_ALU_OUT = 2'd1;
  localparam logic [1:0] WD_BIG_IMM = 2'd2;

  localparam logic [1:0] SRC_B_FOUR      = 2'd0;
  localparam logic [1:0] SRC_B_REG       = 2'd1;
  localparam logic [1:0] SRC_B_SHIFT_OFF = 2'd2;
  localparam logic [1:0] SRC_B_OFF       = 2'd3;

  localparam logic [1:0] PC_ALU_OUT    = 2'd0;
  localparam logic [1:0] PC_JUMP       = 2'd1;
  localparam logic [1:0] PC_ALU_DIRECT = 2'd2;

  localparam logic [3:0] ALU_OP_ADD = 4'h0;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       mem_get_data;
    logic       ir_write;
    logic       mdr_write;
    logic       alu_out_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic [1:0] reg_write_data_select;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       retire;
  } ctrl_t;

  // State that follows DECODE for a given opcode class and MISC subcode.
  function automatic logic [3:0] decode_target(input logic [1:0] cls, input logic [3:0] sub);
    logic [3:0] nxt;
    nxt = S_FAULT;
    case (op_class_t'(cls))
      CLS_ALU_R:  nxt = S_EXEC_R;
      CLS_ALU_I:  nxt = S_EXEC_I;
      CLS_BRANCH: nxt = S_EXEC_BR;
      CLS_MISC: begin
        case (sub)
          SUB_LOAD, SUB_STORE: nxt = S_ADDR;
          SUB_JUMP:            nxt = S_JUMP;
          SUB_LDI:             nxt = S_LDI;
          SUB_HALT:            nxt = S_HALT;
          default:             nxt = S_FAULT;
        endcase
      end
      default: nxt = S_FAULT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Memory request/ready handshake between the sequencer and the RAM.
interface multicycle_sequencer_if;
  logic mem_req;
  logic mem_read;
  logic mem_write;
  logic mem_get_data;
  logic mem_ready;

  modport master (output mem_req, mem_read, mem_write, mem_get_data, input mem_ready);
  modport slave  (input mem_req, mem_read, mem_write, mem_get_data, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Moore strobe decode: state (plus opcode for ALU ops, mem_ready for the
// completion strobes) mapped to every datapath enable and mux select.
module multicycle_ctrl_decode
  import multicycle_pkg::*;
#(
  parameter int OP_SIZE     = 6,
  parameter int ALU_OP_SIZE = 4
) (
  input  logic [3:0]             state,
  input  logic [OP_SIZE-1:0]     opcode,
  input  logic                   mem_ready,
  output ctrl_t                  ctrl,
  output logic [ALU_OP_SIZE-1:0] alu_op,
  output logic                   reg_track_select
);

  op_class_t cls;
  logic      track;
  logic      in_instr;

  assign cls   = op_class_t'(opcode[5:4]);
  assign track = (cls == CLS_ALU_I) || (cls == CLS_MISC);
  // DECODE..MEM_ST are numbered contiguously; the opcode is meaningful only there.
  assign in_instr = (state >= S_DECODE) && (state <= S_MEM_ST);

  always_comb begin
    ctrl             = '0;
    alu_op           = ALU_OP_SIZE'(ALU_OP_ADD);
    reg_track_select = in_instr & track;
    case (state)
      S_FETCH: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.pc_src   = PC_ALU_DIRECT;
        ctrl.ir_write = mem_ready;
        ctrl.pc_write = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b     = SRC_B_SHIFT_OFF;
        ctrl.alu_out_write = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_out_write = 1'b1;
        alu_op             = ALU_OP_SIZE'(opcode[3:0]);
      end
      S_EXEC_I: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_OFF;
        ctrl.alu_out_write = 1'b1;
        alu_op             = ALU_OP_SIZE'(opcode[3:0]);
      end
      S_WB_ALU: begin
        ctrl.reg_write             = 1'b1;
        ctrl.reg_write_data_select = WD_ALU_OUT;
        ctrl.retire                = 1'b1;
      end
      S_EXEC_BR: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PC_ALU_OUT;
        ctrl.retire        = 1'b1;
        alu_op             = ALU_OP_SIZE'(opcode[3:0]);
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_JUMP;
        ctrl.retire   = 1'b1;
      end
      S_LDI: begin
        ctrl.reg_write             = 1'b1;
        ctrl.reg_write_data_select = WD_BIG_IMM;
        ctrl.retire                = 1'b1;
      end
      S_ADDR: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_OFF;
        ctrl.alu_out_write = 1'b1;
      end
      S_MEM_LD: begin
        ctrl.mem_req      = 1'b1;
        ctrl.mem_read     = 1'b1;
        ctrl.mem_get_data = 1'b1;
        ctrl.mdr_write    = mem_ready;
      end
      S_WB_LD: begin
        ctrl.reg_write             = 1'b1;
        ctrl.reg_write_data_select = WD_MDR;
        ctrl.retire                = 1'b1;
      end
      S_MEM_ST: begin
        ctrl.mem_req      = 1'b1;
        ctrl.mem_write    = 1'b1;
        ctrl.mem_get_data = 1'b1;
        ctrl.retire       = mem_ready;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: state register, memory wait/timeout counter,
// sticky halt/fault status and cycle/retired-instruction counters.
module multicycle_sequencer
  import multicycle_pkg::*;
#(
  parameter int OP_SIZE     = 6,
  parameter int ALU_OP_SIZE = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OP_SIZE-1:0]     opcode,
  multicycle_sequencer_if.master mem,
  output logic                   ir_write,
  output logic                   mdr_write,
  output logic                   alu_out_write,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic                   reg_write,
  output logic [1:0]             reg_write_data_select,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [ALU_OP_SIZE-1:0] alu_op,
  output logic [1:0]             pc_src,
  output logic                   reg_track_select,
  output logic [3:0]             state,
  output logic                   halted,
  output logic                   fault,
  output logic [1:0]             fault_code,
  output logic [CNT_WIDTH-1:0]   cycle_count,
  output logic [CNT_WIDTH-1:0]   instr_count
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  ctrl_t             ctrl;
  logic [3:0]        state_nxt;
  logic [1:0]        fault_code_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_phase;
  logic              timeout_hit;

  multicycle_ctrl_decode #(
    .OP_SIZE     (OP_SIZE),
    .ALU_OP_SIZE (ALU_OP_SIZE)
  ) u_decode (
    .state            (state),
    .opcode           (opcode),
    .mem_ready        (mem.mem_ready),
    .ctrl             (ctrl),
    .alu_op           (alu_op),
    .reg_track_select (reg_track_select)
  );

  assign mem.mem_req           = ctrl.mem_req;
  assign mem.mem_read          = ctrl.mem_read;
  assign mem.mem_write         = ctrl.mem_write;
  assign mem.mem_get_data      = ctrl.mem_get_data;
  assign ir_write              = ctrl.ir_write;
  assign mdr_write             = ctrl.mdr_write;
  assign alu_out_write         = ctrl.alu_out_write;
  assign pc_write              = ctrl.pc_write;
  assign pc_write_cond         = ctrl.pc_write_cond;
  assign reg_write             = ctrl.reg_write;
  assign reg_write_data_select = ctrl.reg_write_data_select;
  assign alu_src_a             = ctrl.alu_src_a;
  assign alu_src_b             = ctrl.alu_src_b;
  assign pc_src                = ctrl.pc_src;

  assign halted = (state == S_HALT);
  assign fault  = (state == S_FAULT);

  assign mem_phase = (state == S_FETCH) || (state == S_MEM_LD) || (state == S_MEM_ST);
  // Timeout fires on the last permitted wait cycle only if ready is still low, so ready wins ties.
  assign timeout_hit = (MEM_TIMEOUT > 0) && mem_phase && !mem.mem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nxt      = state;
    fault_code_nxt = fault_code;
    case (state)
      S_FETCH:  if (mem.mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        state_nxt = decode_target(opcode[5:4], opcode[3:0]);
        if (state_nxt == S_FAULT) fault_code_nxt = FAULT_ILLEGAL;
      end
      S_EXEC_R, S_EXEC_I: state_nxt = S_WB_ALU;
      S_WB_ALU, S_EXEC_BR, S_JUMP, S_LDI, S_WB_LD: state_nxt = S_FETCH;
      S_ADDR:   state_nxt = (opcode[3:0] == SUB_STORE) ? S_MEM_ST : S_MEM_LD;
      S_MEM_LD: if (mem.mem_ready) state_nxt = S_WB_LD;
      S_MEM_ST: if (mem.mem_ready) state_nxt = S_FETCH;
      S_HALT, S_FAULT: state_nxt = state;
      default:  state_nxt = S_FETCH;
    endcase
    if (timeout_hit) begin
      state_nxt      = S_FAULT;
      fault_code_nxt = FAULT_TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      fault_code  <= FAULT_NONE;
      wait_cnt    <= '0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      state      <= state_nxt;
      fault_code <= fault_code_nxt;
      // Staying in a memory state means another wait; any transition restarts the count.
      wait_cnt   <= (mem_phase && (state_nxt == state)) ? wait_cnt + WAIT_W'(1) : '0;
      if (!halted && !fault) cycle_count <= cycle_count + CNT_WIDTH'(1);
      if (ctrl.retire)       instr_count <= instr_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized instruction stream checked cycle by cycle against an
// instruction-level model of the sequencer, plus directed corner cases.
module tb_multicycle_sequencer;
  import multicycle_pkg::*;

  localparam int TO = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        ir_write, mdr_write, alu_out_write, pc_write, pc_write_cond, reg_write;
  logic [1:0]  reg_write_data_select, alu_src_b, pc_src, fault_code;
  logic        alu_src_a, reg_track_select, halted, fault;
  logic [3:0]  alu_op, state;
  logic [31:0] cycle_count, instr_count;

  multicycle_sequencer_if bus ();

  multicycle_sequencer #(
    .OP_SIZE(6), .ALU_OP_SIZE(4), .CNT_WIDTH(32), .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem(bus),
    .ir_write(ir_write), .mdr_write(mdr_write), .alu_out_write(alu_out_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .reg_write(reg_write),
    .reg_write_data_select(reg_write_data_select), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .reg_track_select(reg_track_select), .state(state), .halted(halted),
    .fault(fault), .fault_code(fault_code), .cycle_count(cycle_count),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] state;
    logic mem_req, mem_read, mem_write, mem_get_data;
    logic ir_write, mdr_write, alu_out_write, pc_write, pc_write_cond, reg_write;
    logic [1:0] rwds;
    logic       a;
    logic [1:0] b;
    logic [3:0] alu_op;
    logic [1:0] pc_src;
    logic rts, halted, fault;
    logic [1:0] fault_code;
  } obs_t;

  obs_t act, exp_o;
  assign act = {state, bus.mem_req, bus.mem_read, bus.mem_write, bus.mem_get_data,
                ir_write, mdr_write, alu_out_write, pc_write, pc_write_cond, reg_write,
                reg_write_data_select, alu_src_a, alu_src_b, alu_op, pc_src,
                reg_track_select, halted, fault, fault_code};

  int          vectors = 0;
  int          miscompares = 0;
  logic        chk_en = 1'b0;
  logic [31:0] e_cyc, e_ins;
  int          m_cyc, m_ins;
  logic [1:0]  m_fc;

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("strobes", 32'(act), 32'(exp_o));
      check("cycle_count", cycle_count, e_cyc);
      check("instr_count", instr_count, e_ins);
    end
  end

  function automatic obs_t blank(input logic [3:0] s);
    obs_t e;
    e        = '0;
    e.state  = s;
    e.alu_op = ALU_OP_ADD;
    return e;
  endfunction

  // One clock of the model: publish expectation, advance, then update counters.
  task automatic step(input obs_t e, input logic rdy, input logic ret);
    bus.mem_ready = rdy;
    e.fault_code  = m_fc;
    exp_o         = e;
    e_cyc         = m_cyc;
    e_ins         = m_ins;
    chk_en        = 1'b1;
    @(posedge clk); #1;
    if (!e.halted && !e.fault) m_cyc++;
    if (ret) m_ins++;
  endtask

  task automatic mem_access(input logic [3:0] s, input int waits, input logic track);
    obs_t e;
    e              = blank(s);
    e.mem_req      = 1'b1;
    e.mem_read     = (s != S_MEM_ST);
    e.mem_write    = (s == S_MEM_ST);
    e.mem_get_data = (s != S_FETCH);
    e.pc_src       = (s == S_FETCH) ? PC_ALU_DIRECT : PC_ALU_OUT;
    e.rts          = (s != S_FETCH) && track;
    for (int i = 0; i < waits; i++) begin
      if (s == S_FETCH) opcode = 6'($urandom);
      step(e, 1'b0, 1'b0);
    end
    if (s == S_FETCH) opcode = 6'($urandom);
    e.ir_write  = (s == S_FETCH);
    e.pc_write  = (s == S_FETCH);
    e.mdr_write = (s == S_MEM_LD);
    step(e, 1'b1, s == S_MEM_ST);
  endtask

  task automatic stuck(input logic is_halt, input int hold);
    obs_t e;
    e        = blank(is_halt ? S_HALT : S_FAULT);
    e.halted = is_halt;
    e.fault  = !is_halt;
    repeat (hold) step(e, 1'($urandom), 1'b0);
  endtask

  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    obs_t e;
    logic [1:0] cls;
    logic [3:0] sub;
    logic       track;
    mem_access(S_FETCH, wf, 1'b0);
    opcode = op;
    cls    = op[5:4];
    sub    = op[3:0];
    track  = (cls == 2'd1) || (cls == 2'd3);
    e = blank(S_DECODE); e.b = SRC_B_SHIFT_OFF; e.alu_out_write = 1'b1; e.rts = track;
    step(e, 1'($urandom), 1'b0);
    case (cls)
      2'd0, 2'd1: begin
        e = blank(cls == 2'd0 ? S_EXEC_R : S_EXEC_I);
        e.a = 1'b1; e.b = (cls == 2'd0) ? SRC_B_REG : SRC_B_OFF;
        e.alu_out_write = 1'b1; e.alu_op = sub; e.rts = track;
        step(e, 1'($urandom), 1'b0);
        e = blank(S_WB_ALU); e.reg_write = 1'b1; e.rwds = WD_ALU_OUT; e.rts = track;
        step(e, 1'($urandom), 1'b1);
      end
      2'd2: begin
        e = blank(S_EXEC_BR); e.a = 1'b1; e.b = SRC_B_REG; e.pc_write_cond = 1'b1;
        e.pc_src = PC_ALU_OUT; e.alu_op = sub;
        step(e, 1'($urandom), 1'b1);
      end
      default: begin
        if (sub == SUB_LOAD || sub == SUB_STORE) begin
          e = blank(S_ADDR); e.a = 1'b1; e.b = SRC_B_OFF; e.alu_out_write = 1'b1; e.rts = 1'b1;
          step(e, 1'($urandom), 1'b0);
          mem_access(sub == SUB_STORE ? S_MEM_ST : S_MEM_LD, wm, 1'b1);
          if (sub == SUB_LOAD) begin
            e = blank(S_WB_LD); e.reg_write = 1'b1; e.rwds = WD_MDR; e.rts = 1'b1;
            step(e, 1'($urandom), 1'b1);
          end
        end else if (sub == SUB_JUMP) begin
          e = blank(S_JUMP); e.pc_write = 1'b1; e.pc_src = PC_JUMP; e.rts = 1'b1;
          step(e, 1'($urandom), 1'b1);
        end else if (sub == SUB_LDI) begin
          e = blank(S_LDI); e.reg_write = 1'b1; e.rwds = WD_BIG_IMM; e.rts = 1'b1;
          step(e, 1'($urandom), 1'b1);
        end else if (sub == SUB_HALT) begin
          stuck(1'b1, 6);
        end else begin
          m_fc = FAULT_ILLEGAL;
          stuck(1'b0, 10);
        end
      end
    endcase
  endtask

  task automatic do_reset();
    chk_en        = 1'b0;
    rst           = 1'b1;
    bus.mem_ready = 1'b0;
    opcode        = 6'h00;
    @(posedge clk); #1;
    check("rst_state", 32'(state), 32'(S_FETCH));
    check("rst_mem_req", 32'(bus.mem_req), 32'd1);
    check("rst_cycle_count", cycle_count, 32'd0);
    check("rst_instr_count", instr_count, 32'd0);
    check("rst_status", 32'({halted, fault, fault_code}), 32'd0);
    rst   = 1'b0;
    m_cyc = 0;
    m_ins = 0;
    m_fc  = FAULT_NONE;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [1:0] cls;
    logic [3:0] sub;
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    opcode = 6'h00;
    do_reset();

    run_instr(6'h02, 0, 0);
    check("alu_r_instr_count", instr_count, 32'd1);
    check("alu_r_cycle_count", cycle_count, 32'd4);

    c0 = cycle_count;
    run_instr(6'h30, 0, 2);
    check("load_latency", cycle_count - 32'(c0), 32'd7);
    run_instr(6'h31, 0, 0);
    run_instr(6'h32, 0, 0);
    check("seq_instr_count", instr_count, 32'd4);
    check("seq_cycle_count", cycle_count, 32'd18);

    for (int n = 0; n < 200; n++) begin
      cls = 2'($urandom_range(0, 3));
      sub = (cls == 2'd3) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      run_instr({cls, sub}, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
    end

    // Fetch never completes: timeout after TO wait cycles.
    do_reset();
    begin
      obs_t e;
      e = blank(S_FETCH); e.mem_req = 1'b1; e.mem_read = 1'b1; e.pc_src = PC_ALU_DIRECT;
      repeat (TO) step(e, 1'b0, 1'b0);
    end
    m_fc = FAULT_TIMEOUT;
    stuck(1'b0, 10);
    check("timeout_code", 32'(fault_code), 32'd2);
    check("timeout_frozen", cycle_count, 32'd3);

    // Ready on the last permitted cycle wins over the timeout.
    do_reset();
    run_instr(6'h12, TO - 1, 0);
    check("late_ready_cycles", cycle_count, 32'd6);
    check("late_ready_instr", instr_count, 32'd1);

    do_reset();
    run_instr(6'h37, 0, 0);
    check("illegal_code", 32'(fault_code), 32'd1);
    check("illegal_frozen", cycle_count, 32'd2);

    do_reset();
    run_instr(6'h3F, 0, 0);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_frozen", cycle_count, 32'd2);
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("halt_rst_state", 32'(state), 32'(S_FETCH));
    check("halt_rst_cycle", cycle_count, 32'd0);
    check("halt_rst_instr", instr_count, 32'd0);
    check("halt_rst_flags", 32'({halted, fault, bus.mem_req}), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
